// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a small N_IN-input gate, samples its output once per vector
// and grades the observed truth table against EXPECT. Define TT_SEQ_GRAY_EN for Gray-order sweeps.
module truth_table_sequencer #(
    parameter int                     N_IN   = 2,
    parameter int                     HOLD   = 1,
    parameter logic [(2**N_IN)-1:0]   EXPECT = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [N_IN-1:0]       vec,
    input  logic                  dut_out,
    output logic                  sample,
    output logic                  busy,
    output logic                  done,
    output logic [(2**N_IN)-1:0]  result,
    output logic [N_IN:0]         err_cnt,
    output logic                  pass
);

    localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] LAST_POS  = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [N_IN-1:0]        pos, pos_nxt;
    logic [HW-1:0]          hold_cnt, hold_nxt;
    logic [(2**N_IN)-1:0]   result_nxt;
    logic [N_IN:0]          err_nxt;

    // pos counts sweep steps 0..2**N_IN-1; vec is that step mapped to the driven vector.
`ifdef TT_SEQ_GRAY_EN
    logic [N_IN-1:0] gray_vec;

    function automatic logic [N_IN-1:0] to_gray(input logic [N_IN-1:0] p);
        return p ^ (p >> 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) gray_vec <= '0;
        else     gray_vec <= to_gray(pos_nxt);
    end

    assign vec = gray_vec;
`else
    assign vec = pos;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pos      <= '0;
            hold_cnt <= '0;
            result   <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            hold_cnt <= hold_nxt;
            result   <= result_nxt;
            err_cnt  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        hold_nxt   = hold_cnt;
        result_nxt = result;
        err_nxt    = err_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = DRIVE;
                    pos_nxt    = '0;
                    hold_nxt   = '0;
                    result_nxt = '0;
                    err_nxt    = '0;
                end
            end
            DRIVE: begin
                if (hold_cnt == HOLD_LAST) state_nxt = SAMPLE;
                else                       hold_nxt  = hold_cnt + 1'b1;
            end
            SAMPLE: begin
                result_nxt[vec] = dut_out;
                if (dut_out != EXPECT[vec]) err_nxt = err_cnt + 1'b1;
                if (pos == LAST_POS) begin
                    state_nxt = DONE;
                end else begin
                    pos_nxt   = pos + 1'b1;
                    hold_nxt  = '0;
                    state_nxt = DRIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sample = (state == SAMPLE);
    assign busy   = (state == DRIVE) || (state == SAMPLE);
    assign done   = (state == DONE);
    assign pass   = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: instance a (HOLD=1, AND/OR gate), instance b (HOLD=3, AND).
module tb_truth_table_sequencer;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic       sel_or;
    logic [1:0] vec_a, vec_b;
    logic       dut_out_a, dut_out_b;
    logic       sample_a, sample_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0] result_a, result_b;
    logic [2:0] err_a, err_b;
    logic [1:0] prev;

    int tests = 0;
    int fails = 0;

`ifdef TT_SEQ_GRAY_EN
    localparam int ORD [4] = '{0, 1, 3, 2};
`else
    localparam int ORD [4] = '{0, 1, 2, 3};
`endif

    assign dut_out_a = sel_or ? (vec_a[0] | vec_a[1]) : (vec_a[0] & vec_a[1]);
    assign dut_out_b = vec_b[0] & vec_b[1];

    truth_table_sequencer #(.N_IN(2), .HOLD(1), .EXPECT(4'b1000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .dut_out(dut_out_a),
        .sample(sample_a), .busy(busy_a), .done(done_a), .result(result_a),
        .err_cnt(err_a), .pass(pass_a)
    );

    truth_table_sequencer #(.N_IN(2), .HOLD(3), .EXPECT(4'b1000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .dut_out(dut_out_b),
        .sample(sample_b), .busy(busy_b), .done(done_b), .result(result_b),
        .err_cnt(err_b), .pass(pass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_vec"},    32'(vec_a),    0);
        check({tag, "_busy"},   32'(busy_a),   0);
        check({tag, "_done"},   32'(done_a),   0);
        check({tag, "_sample"}, 32'(sample_a), 0);
        check({tag, "_result"}, 32'(result_a), 0);
        check({tag, "_err"},    32'(err_a),    0);
        check({tag, "_pass"},   32'(pass_a),   0);
    endtask

    // Runs one HOLD=1 sweep on instance a from a start pulse, checking each cycle.
    task automatic sweep_a(input string tag, input logic [3:0] exp_res,
                           input logic [2:0] exp_err, input logic exp_pass);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, "_clr_result"}, 32'(result_a), 0);
        check({tag, "_clr_err"},    32'(err_a),    0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_vec%0d", tag, i),    32'(vec_a),    32'(ORD[i/2]));
            check($sformatf("%s_sample%0d", tag, i), 32'(sample_a), 32'(i % 2 == 1));
            check($sformatf("%s_busy%0d", tag, i),   32'(busy_a),   1);
            check($sformatf("%s_done%0d", tag, i),   32'(done_a),   0);
`ifdef TT_SEQ_GRAY_EN
            if (i > 0 && i % 2 == 0)
                check($sformatf("%s_onebit%0d", tag, i), 32'($countones(vec_a ^ prev)), 1);
`endif
            prev = vec_a;
            tick();
        end
        check({tag, "_done"},   32'(done_a),   1);
        check({tag, "_busy"},   32'(busy_a),   0);
        check({tag, "_result"}, 32'(result_a), 32'(exp_res));
        check({tag, "_err"},    32'(err_a),    32'(exp_err));
        check({tag, "_pass"},   32'(pass_a),   32'(exp_pass));
        check({tag, "_vecfin"}, 32'(vec_a),    32'(ORD[3]));
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel_or = 1'b0; prev = '0;

        // Reset then idle
        tick();
        tick();
        check_idle_a("rst");
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle_a($sformatf("idle%0d", c));
            check($sformatf("idle_b_busy%0d", c), 32'(busy_b), 0);
        end

        // rst wins over start
        rst = 1'b1; start_a = 1'b1;
        tick();
        rst = 1'b0; start_a = 1'b0;
        check_idle_a("rst_vs_start");

        // AND gate, HOLD=1
        sweep_a("and", 4'b1000, 3'd0, 1'b1);

        // OR gate against AND expectation, restarted from DONE
        sel_or = 1'b1;
        sweep_a("or", 4'b1110, 3'd2, 1'b0);
        sel_or = 1'b0;

        // Restart from DONE repeats the AND sweep identically
        sweep_a("and2", 4'b1000, 3'd0, 1'b1);

        // HOLD=3 on instance b, with an ignored mid-sweep start
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            start_b = (i == 5);
            check($sformatf("h3_vec%0d", i),    32'(vec_b),    32'(ORD[i/4]));
            check($sformatf("h3_sample%0d", i), 32'(sample_b), 32'(i % 4 == 3));
            check($sformatf("h3_busy%0d", i),   32'(busy_b),   1);
            check($sformatf("h3_done%0d", i),   32'(done_b),   0);
            tick();
        end
        start_b = 1'b0;
        check("h3_done",   32'(done_b),   1);
        check("h3_busy",   32'(busy_b),   0);
        check("h3_result", 32'(result_b), 32'h8);
        check("h3_err",    32'(err_b),    0);
        check("h3_pass",   32'(pass_b),   1);

        // Mid-sweep reset during the third vector's sample, with OR so partial result is nonzero
        sel_or = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_sample", 32'(sample_a), 1);
        check("mid_vec",    32'(vec_a),    32'(ORD[2]));
        check("mid_partial", 32'(result_a), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_a("midrst");
        check("midrst_b_done",   32'(done_b),   0);
        check("midrst_b_result", 32'(result_b), 0);
        tick();
        check_idle_a("midrst_hold");
        sel_or = 1'b0;
        sweep_a("after_rst", 4'b1000, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Upstream stimulus stage for small combinational exercise gates, such as the 2-input AND gate.
- Sweeps every input combination of an N_IN-input DUT and holds each vector for a programmable settle time.
- Samples the DUT output once per vector and builds the observed truth table.
- Compares that table against an expected table and reports mismatches, so a bench can print and grade results without hand-written loops.

Parameters:
- N_IN, 2, DUT input count; legal range 1..6.
- HOLD, 1, cycles each vector is driven before it is sampled; must be >= 1.
- EXPECT, 4'b1000 (width 2**N_IN), expected DUT output indexed by vector value; the default is AND.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- vec  out  N_IN  vector driven to DUT inputs; bit 0 goes to the DUT's first input.
- dut_out  in  1  DUT output, combinational from vec.
- sample  out  1  high during the cycle in which dut_out is captured.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  level; high in DONE.
- result  out  2**N_IN  observed truth table; bit i = DUT output for vec==i.
- err_cnt  out  N_IN+1  count of vectors where the observed bit != EXPECT bit.
- pass  out  1  done && err_cnt==0.

Behaviour:
- Reset: state=IDLE; vec=0, sample=0, busy=0, done=0, result=0, err_cnt=0, pass=0.
- rst wins over every other input in every state.
- A mid-sweep reset abandons the sweep; no partial result is retained.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: on start, next cycle enters DRIVE with vec=first vector, hold_cnt=0, result=0, err_cnt=0.
- DRIVE: vec stable; hold_cnt increments each cycle; when hold_cnt==HOLD-1, next state is SAMPLE.
- SAMPLE: sample=1, vec unchanged.
  - At the edge ending this cycle: result[vec] <= dut_out.
  - If dut_out != EXPECT[vec], err_cnt increments.
  - If this is the last vector, next state is DONE. Otherwise vec advances to the next vector, hold_cnt=0, next state DRIVE.
- DONE: done=1. result, err_cnt and vec hold their final values. start restarts exactly as from IDLE, clearing result and err_cnt.
- start is ignored while busy; no queuing.
- Latency: start accepted at edge k gives busy=1 from k+1 and done=1 from k+1+2**N_IN*(HOLD+1), with busy=0 in that same cycle.
- Vector order: binary ascending 0..2**N_IN-1; the last vector is 2**N_IN-1.
- err_cnt width covers the maximum count 2**N_IN without overflow; the counter saturates by construction.

Optional Feature:
- Macro TT_SEQ_GRAY_EN.
- Defined:
  - vec steps through reflected Gray order g(j)=j^(j>>1), j=0..2**N_IN-1, so only one DUT input toggles per step.
  - The last vector is g(2**N_IN-1).
  - result and EXPECT remain indexed by the binary value of vec, so the final result is identical to binary mode.
  - Timing is unchanged.
- Undefined: binary ascending order only; no Gray logic is synthesised.

Test Plan:
1. Reset then idle: assert rst 2 cycles, hold start=0 for 10 cycles -> vec=0, busy=0, done=0, result=0, err_cnt=0 throughout.
2. AND DUT, N_IN=2, HOLD=1: start pulse at cycle 0 -> vec sequence 0,0,1,1,2,2,3,3; sample on odd cycles; done at cycle 9; result=4'b1000, err_cnt=0, pass=1.
3. OR DUT with default EXPECT -> result=4'b1110, err_cnt=2, pass=0.
4. HOLD=3: each vec held 4 cycles, sample on the 4th; done 17 cycles after start. start pulsed mid-sweep -> ignored, no timing change.
5. rst asserted during SAMPLE of vec=2, then start -> outputs at reset values, and the new sweep restarts from vec=0 with result cleared. Also restart from DONE via start -> result cleared and sweep repeats identically.
6. TT_SEQ_GRAY_EN defined, AND DUT -> vec order 0,1,3,2; result=4'b1000, pass=1; exactly one vec bit changes per step.
